// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipe scheduler: stage indices, fetch FSM
// encoding and the default perf-counter width.
package pipe_pkg;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;
  localparam int unsigned STG_WB  = 4;
  localparam int unsigned NUM_STG = 5;

  // RUN: fetch responses feed ID. CANCEL: the next response belongs to a
  // request issued before a flush and must be dropped.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_CANCEL = 1'b1
  } fetch_state_e;

  localparam int unsigned CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake bundle between the pipe datapath (master) and the stage scheduler
// (slave): fetch status, per-stage ready_go, commit events and scheduler outputs.
interface pipe_stage_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic             fetch_req_ok;
  logic             fetch_data_ok;
  logic             id_ready_go;
  logic             ex_ready_go;
  logic             mem_ready_go;
  logic             ex_wb;
  logic             eret_flush;

  logic             if_allowin;
  logic             id_allowin;
  logic             ex_allowin;
  logic             mem_allowin;
  logic             wb_allowin;
  logic             id_valid;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             flush;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fetch_req_ok, fetch_data_ok, id_ready_go, ex_ready_go, mem_ready_go,
           ex_wb, eret_flush,
    input  if_allowin, id_allowin, ex_allowin, mem_allowin, wb_allowin,
           id_valid, ex_valid, mem_valid, wb_valid, flush, retire_cnt, stall_cnt
  );

  modport slave (
    input  fetch_req_ok, fetch_data_ok, id_ready_go, ex_ready_go, mem_ready_go,
           ex_wb, eret_flush,
    output if_allowin, id_allowin, ex_allowin, mem_allowin, wb_allowin,
           id_valid, ex_valid, mem_valid, wb_valid, flush, retire_cnt, stall_cnt
  );

endinterface

// File: rtl/stage_valid_ctrl.sv
// Valid bit and allowin/to_next handshake for a single pipeline stage.
module stage_valid_ctrl (
  input  logic clk,
  input  logic resetn,
  input  logic valid_in,
  input  logic ready_go,
  input  logic next_allowin,
  input  logic flush,
  output logic valid,
  output logic allowin,
  output logic to_next
);

  logic valid_q;

  assign allowin = ~valid_q | (ready_go & next_allowin);
  assign to_next = valid_q & ready_go;
  assign valid   = valid_q;

  // Flush kills the stage even when it is stalled and not accepting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (allowin) begin
      valid_q <= valid_in;
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/allowin scheduler for the IF-ID-EX-MEM-WB pipe with WB flush and stale
// fetch cancellation. Define PIPE_PERF_EN to build the retire/stall counters.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input logic               clk,
  input logic               resetn,
  pipe_stage_ctrl_if.slave  bus
);

  logic id_valid, ex_valid, mem_valid, wb_valid;
  logic id_allowin, ex_allowin, mem_allowin, wb_allowin;
  logic id_to_next, ex_to_next, mem_to_next, wb_to_next;
  logic if_allowin;
  logic flush;
  logic fetch_accept;

  fetch_state_e state_q, state_d;
  logic         pending_q, pending_d;

  // IF holds no valid bit of its own; it may hand over whenever ID can take it.
  assign if_allowin = id_allowin;

  // WB always completes in one cycle, so wb_to_next marks a committing
  // instruction. ex_wb takes redirect priority in the PC mux, outside this block.
  assign flush = wb_to_next & (bus.ex_wb | bus.eret_flush);

  assign fetch_accept = bus.fetch_data_ok & (state_q == ST_RUN) & if_allowin & ~flush;

  stage_valid_ctrl u_id (
    .clk          (clk),
    .resetn       (resetn),
    .valid_in     (fetch_accept),
    .ready_go     (bus.id_ready_go),
    .next_allowin (ex_allowin),
    .flush        (flush),
    .valid        (id_valid),
    .allowin      (id_allowin),
    .to_next      (id_to_next)
  );

  stage_valid_ctrl u_ex (
    .clk          (clk),
    .resetn       (resetn),
    .valid_in     (id_to_next),
    .ready_go     (bus.ex_ready_go),
    .next_allowin (mem_allowin),
    .flush        (flush),
    .valid        (ex_valid),
    .allowin      (ex_allowin),
    .to_next      (ex_to_next)
  );

  stage_valid_ctrl u_mem (
    .clk          (clk),
    .resetn       (resetn),
    .valid_in     (ex_to_next),
    .ready_go     (bus.mem_ready_go),
    .next_allowin (wb_allowin),
    .flush        (flush),
    .valid        (mem_valid),
    .allowin      (mem_allowin),
    .to_next      (mem_to_next)
  );

  stage_valid_ctrl u_wb (
    .clk          (clk),
    .resetn       (resetn),
    .valid_in     (mem_to_next),
    .ready_go     (1'b1),
    .next_allowin (1'b1),
    .flush        (flush),
    .valid        (wb_valid),
    .allowin      (wb_allowin),
    .to_next      (wb_to_next)
  );

  // A request issued in the same cycle as a response replaces the old one.
  always_comb begin
    pending_d = pending_q;
    if (bus.fetch_req_ok) begin
      pending_d = 1'b1;
    end else if (bus.fetch_data_ok) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush && pending_q && !bus.fetch_data_ok) begin
          state_d = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        if (bus.fetch_data_ok && !flush) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] stall_q;
  logic             bubble;

  assign bubble = ~wb_valid & (id_valid | ex_valid | mem_valid);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_q + CNT_W'(wb_valid);
      stall_q  <= stall_q + CNT_W'(bubble);
    end
  end

  assign bus.retire_cnt = retire_q;
  assign bus.stall_cnt  = stall_q;
`else
  assign bus.retire_cnt = '0;
  assign bus.stall_cnt  = '0;
`endif

  assign bus.if_allowin  = if_allowin;
  assign bus.id_allowin  = id_allowin;
  assign bus.ex_allowin  = ex_allowin;
  assign bus.mem_allowin = mem_allowin;
  assign bus.wb_allowin  = wb_allowin;
  assign bus.id_valid    = id_valid;
  assign bus.ex_valid    = ex_valid;
  assign bus.mem_valid   = mem_valid;
  assign bus.wb_valid    = wb_valid;
  assign bus.flush       = flush;

endmodule
